// File: rtl/arm_data_responder_pkg.sv
// Shared constants for the ARM data-bus responder: MMIO register map, CTRL bit
// positions and a byte-lane merge helper.
package arm_data_responder_pkg;

  localparam logic [15:0] MMIO_HI_DEFAULT = 16'hFFFF;

  // MMIO word offsets (memaddr[3:2])
  localparam logic [1:0] OFF_LOAD   = 2'd0;
  localparam logic [1:0] OFF_COUNT  = 2'd1;
  localparam logic [1:0] OFF_CTRL   = 2'd2;
  localparam logic [1:0] OFF_STATUS = 2'd3;

  // CTRL bit indices
  localparam int CTRL_EN = 0;
  localparam int CTRL_AR = 1;
  localparam int CTRL_IE = 2;

  function automatic logic [31:0] apply_be(input logic [31:0] old_word,
                                           input logic [31:0] new_word,
                                           input logic [3:0]  be);
    logic [31:0] merged;
    merged = old_word;
    for (int i = 0; i < 4; i++)
      if (be[i]) merged[8*i +: 8] = new_word[8*i +: 8];
    return merged;
  endfunction

endpackage

// File: rtl/arm_irq_timer.sv
// Memory-mapped interval timer: LOAD/COUNT/CTRL/STATUS registers, the
// down-counter, the pending flag and the active-low interrupt to the core.
module arm_irq_timer
  import arm_data_responder_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic        wr,
  input  logic [1:0]  offset,
  input  logic [3:0]  be,
  input  logic [31:0] wdata,
  output logic [31:0] rdata,
  output logic        nIRQ
);

  logic [31:0] load;
  logic [31:0] count;
  logic [2:0]  ctrl;
  logic        pending;

  logic        ctrl_wr;
  logic [2:0]  ctrl_next;
  logic        enable_rise;
  logic        expire;
  logic        status_clr;

  assign ctrl_wr     = wr && offset == OFF_CTRL && be[0];
  assign ctrl_next   = ctrl_wr ? wdata[2:0] : ctrl;
  assign enable_rise = ctrl_next[CTRL_EN] && !ctrl[CTRL_EN];
  // Expiry uses the enable in force during this cycle; a rise reloads instead.
  assign expire      = ctrl[CTRL_EN] && count == 32'd1 && !enable_rise;
  assign status_clr  = wr && offset == OFF_STATUS && be[0] && wdata[0];

  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // pre-edge values regardless of statement order.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      load    <= '0;
      count   <= '0;
      ctrl    <= '0;
      pending <= 1'b0;
    end else begin
      if (wr && offset == OFF_LOAD)
        load <= apply_be(load, wdata, be);
      ctrl <= ctrl_next;

      if (enable_rise)
        count <= load;
      else if (ctrl[CTRL_EN] && count > 32'd1)
        count <= count - 32'd1;
      else if (expire)
        count <= ctrl[CTRL_AR] ? load : 32'd0;

      // A same-cycle expiry beats a W1C clear.
      pending <= expire || (pending && !status_clr);
    end
  end

  assign nIRQ = ~(pending & ctrl[CTRL_IE]);

  // NOTE: always_comb outputs get a default first so no path infers a latch.
  always_comb begin
    rdata = '0;
    unique case (offset)
      OFF_LOAD:   rdata = load;
      OFF_COUNT:  rdata = count;
      OFF_CTRL:   rdata = {29'd0, ctrl};
      OFF_STATUS: rdata = {31'd0, pending};
      default:    rdata = '0;
    endcase
  end

endmodule

// File: rtl/arm_data_responder.sv
// Far end of the single-cycle ARM core's data bus: address decode, byte-enabled
// word RAM with zero-latency reads, the MMIO timer and the unmapped-write flag.
module arm_data_responder
  import arm_data_responder_pkg::*;
#(
  parameter int          DEPTH_LOG2 = 10,
  parameter logic [15:0] MMIO_HI    = MMIO_HI_DEFAULT
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] memaddr,
  input  logic        memwrite,
  input  logic        memread,
  input  logic [3:0]  be,
  input  logic [31:0] writedata,
  output logic [31:0] readdata,
  output logic        nIRQ,
  output logic        addr_err
);

  localparam logic [31:0] RAM_BYTES = 32'd4 << DEPTH_LOG2;

  logic                  is_mmio;
  logic                  is_ram;
  logic [DEPTH_LOG2-1:0] word_idx;
  logic [31:0]           timer_rdata;
  logic [31:0]           mem [2**DEPTH_LOG2];

  assign is_mmio  = memaddr[31:16] == MMIO_HI;
  assign is_ram   = !is_mmio && memaddr < RAM_BYTES;
  assign word_idx = memaddr[DEPTH_LOG2+1:2];

  // NOTE: the RAM array is deliberately not reset so it maps onto plain
  // memory macros; contents are undefined until written.
  always_ff @(posedge clk) begin
    if (memwrite && is_ram)
      for (int i = 0; i < 4; i++)
        if (be[i]) mem[word_idx][8*i +: 8] <= writedata[8*i +: 8];
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) addr_err <= 1'b0;
    else       addr_err <= memwrite && !is_mmio && !is_ram;
  end

  arm_irq_timer u_timer (
    .clk   (clk),
    .reset (reset),
    .wr    (memwrite && is_mmio),
    .offset(memaddr[3:2]),
    .be    (be),
    .wdata (writedata),
    .rdata (timer_rdata),
    .nIRQ  (nIRQ)
  );

  // Reads are combinational so the single-cycle core sees data the same cycle.
  always_comb begin
    readdata = '0;
    if (memread) begin
      if (is_mmio)     readdata = timer_rdata;
      else if (is_ram) readdata = mem[word_idx];
    end
  end

endmodule

// File: tb/tb_arm_data_responder.sv
// Self-checking bench for arm_data_responder: directed scenarios followed by
// random bus traffic, all compared against a behavioural model of the bus.
module tb_arm_data_responder;

  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] memaddr;
  logic        memwrite;
  logic        memread;
  logic [3:0]  be;
  logic [31:0] writedata;
  logic [31:0] readdata;
  logic        nIRQ;
  logic        addr_err;

  always #5 clk = ~clk;

  arm_data_responder dut (
    .clk      (clk),
    .reset    (reset),
    .memaddr  (memaddr),
    .memwrite (memwrite),
    .memread  (memread),
    .be       (be),
    .writedata(writedata),
    .readdata (readdata),
    .nIRQ     (nIRQ),
    .addr_err (addr_err)
  );

  localparam logic [31:0] A_LOAD   = 32'hFFFF_0000;
  localparam logic [31:0] A_COUNT  = 32'hFFFF_0004;
  localparam logic [31:0] A_CTRL   = 32'hFFFF_0008;
  localparam logic [31:0] A_STATUS = 32'hFFFF_000C;
  localparam logic [31:0] RAM_TOP  = 32'd4096;

  int n_checks = 0;
  int n_errors = 0;

  // Reference model state: known RAM words by word index, timer registers.
  logic [31:0] ram_m [int];
  logic [31:0] load_m, count_m;
  bit          en_m, ar_m, ie_m, pend_m, err_m;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] merge(input logic [31:0] o, input logic [31:0] n, input logic [3:0] b);
    logic [31:0] r;
    r = o;
    for (int i = 0; i < 4; i++) if (b[i]) r[8*i +: 8] = n[8*i +: 8];
    return r;
  endfunction

  // Returns 0 when the expected value is unknown (RAM word never fully written).
  function automatic bit model_read(input logic [31:0] a, output logic [31:0] v);
    v = '0;
    if (a[31:16] == 16'hFFFF) begin
      case (a[3:2])
        2'd0:    v = load_m;
        2'd1:    v = count_m;
        2'd2:    v = {29'd0, ie_m, ar_m, en_m};
        default: v = {31'd0, pend_m};
      endcase
    end else if (a < RAM_TOP) begin
      if (!ram_m.exists(int'(a >> 2))) return 1'b0;
      v = ram_m[int'(a >> 2)];
    end
    return 1'b1;
  endfunction

  function automatic void model_reset();
    load_m = '0; count_m = '0;
    en_m = 0; ar_m = 0; ie_m = 0; pend_m = 0; err_m = 0;
  endfunction

  // One bus cycle: drive after negedge, check outputs, then advance the model at posedge.
  task automatic cycle(input logic [31:0] a, input bit wr, input bit rd,
                       input logic [3:0] b, input logic [31:0] d, input string tag);
    logic [31:0] exp, nc;
    bit mmio, set, clr;
    int idx;
    @(negedge clk);
    memaddr = a; memwrite = wr; memread = rd; be = b; writedata = d;
    #1;
    check({tag, "/nIRQ"}, {31'd0, nIRQ}, {31'd0, ~(pend_m & ie_m)});
    check({tag, "/addr_err"}, {31'd0, addr_err}, {31'd0, err_m});
    if (!rd) check({tag, "/rd_idle"}, readdata, 32'd0);
    else if (model_read(a, exp)) check({tag, "/readdata"}, readdata, exp);
    @(posedge clk);
    mmio  = a[31:16] == 16'hFFFF;
    err_m = wr && !mmio && a >= RAM_TOP;
    set = 0;
    nc  = count_m;
    if (wr && mmio && a[3:2] == 2'd2 && b[0] && d[0] && !en_m) nc = load_m;
    else if (en_m && count_m > 1) nc = count_m - 1;
    else if (en_m && count_m == 1) begin nc = ar_m ? load_m : 32'd0; set = 1; end
    clr     = wr && mmio && a[3:2] == 2'd3 && b[0] && d[0];
    pend_m  = set || (pend_m && !clr);
    count_m = nc;
    if (wr && mmio && a[3:2] == 2'd0) load_m = merge(load_m, d, b);
    if (wr && mmio && a[3:2] == 2'd2 && b[0]) {ie_m, ar_m, en_m} = d[2:0];
    if (wr && !mmio && a < RAM_TOP) begin
      idx = int'(a >> 2);
      if (b == 4'hF) ram_m[idx] = d;
      else if (ram_m.exists(idx)) ram_m[idx] = merge(ram_m[idx], d, b);
    end
  endtask

  task automatic wr32(input logic [31:0] a, input logic [31:0] d, input string tag);
    cycle(a, 1, 0, 4'hF, d, tag);
  endtask

  task automatic rd32(input logic [31:0] a, input string tag);
    cycle(a, 0, 1, 4'h0, 32'h0, tag);
  endtask

  initial begin
    logic [31:0] a, d;
    int sel;
    reset = 1'b1; memaddr = '0; memwrite = 0; memread = 0; be = '0; writedata = '0;
    model_reset();
    repeat (2) @(negedge clk);
    reset = 1'b0;

    // Reset state of the register file
    rd32(A_LOAD, "rst_load"); rd32(A_COUNT, "rst_count");
    rd32(A_CTRL, "rst_ctrl"); rd32(A_STATUS, "rst_status");

    // Full and partial RAM writes
    wr32(32'h10, 32'hDEAD_BEEF, "t1_w");
    rd32(32'h10, "t1_r");
    check("t1_full", readdata, 32'hDEAD_BEEF);
    cycle(32'h10, 1, 0, 4'b0001, 32'h0000_00AA, "t1_wb");
    rd32(32'h12, "t1_rb");
    check("t1_byte", readdata, 32'hDEAD_BEAA);

    // One-shot expiry with interrupt enabled
    wr32(A_LOAD, 32'd3, "t2_load");
    wr32(A_CTRL, 32'b101, "t2_ctrl");
    for (int i = 0; i < 6; i++) rd32(A_COUNT, "t2_count");
    rd32(A_STATUS, "t2_status");
    check("t2_nirq_low", {31'd0, nIRQ}, 32'd0);
    wr32(A_STATUS, 32'd1, "t2_w1c");
    wr32(A_CTRL, 32'd0, "t2_stop");

    // Auto-reload; W1C on non-reload then reload cycles
    wr32(A_LOAD, 32'd2, "t3_load");
    wr32(A_CTRL, 32'b111, "t3_ctrl");
    for (int i = 0; i < 4; i++) rd32(A_COUNT, "t3_count");
    for (int i = 0; i < 4; i++) wr32(A_STATUS, 32'd1, "t3_w1c");
    rd32(A_STATUS, "t3_status");
    wr32(A_CTRL, 32'd0, "t3_stop");
    wr32(A_STATUS, 32'd1, "t3_clr");

    // Expiry with irq_en=0, then enabling the interrupt
    wr32(A_LOAD, 32'd1, "t4_load");
    wr32(A_CTRL, 32'b001, "t4_ctrl");
    rd32(A_STATUS, "t4_st0");
    rd32(A_STATUS, "t4_st1");
    wr32(A_CTRL, 32'b101, "t4_ie");
    rd32(A_STATUS, "t4_st2");
    check("t4_nirq_low", {31'd0, nIRQ}, 32'd0);
    wr32(A_CTRL, 32'd0, "t4_stop");
    wr32(A_STATUS, 32'd1, "t4_clr");

    // Unmapped write: single-cycle error, no RAM aliasing
    wr32(32'h0, 32'h0BAD_0000, "t5_w0");
    wr32(32'h8000_0000, 32'h1234_5678, "t5_wbad");
    rd32(32'h8000_0000, "t5_rbad");
    check("t5_err_pulse", {31'd0, addr_err}, 32'd1);
    rd32(32'h0, "t5_r0");
    check("t5_err_clear", {31'd0, addr_err}, 32'd0);
    wr32(32'h1000, 32'hFFFF_FFFF, "t5_wtop");
    rd32(32'hFFC, "t5_rlast");

    // Random traffic: seed a few RAM words first so partial writes stay predictable
    for (int i = 0; i < 8; i++) wr32(32'(i * 4), $urandom, "seed");
    wr32(32'hFFC, $urandom, "seed_top");
    for (int n = 0; n < 600; n++) begin
      sel = $urandom_range(0, 7);
      d   = $urandom;
      if (sel < 3) begin
        a = ($urandom_range(0, 9) == 9) ? 32'hFFC : 32'($urandom_range(0, 7) * 4);
        a = a | 32'($urandom_range(0, 3));
      end else if (sel < 7) begin
        a = 32'hFFFF_0000 | 32'($urandom_range(0, 15) << 2);
        if (a[3:2] == 2'd0) d = 32'($urandom_range(0, 5));
      end else begin
        case ($urandom_range(0, 2))
          0:       a = 32'h0000_1000;
          1:       a = 32'h8000_0000;
          default: a = 32'hFFFE_0000;
        endcase
      end
      cycle(a, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
            ($urandom_range(0, 1) == 1) ? 4'hF : 4'($urandom), d, "rnd");
    end

    // Asynchronous reset mid-count with interrupt pending
    wr32(A_CTRL, 32'd0, "t6_stop");
    wr32(A_LOAD, 32'd1, "t6_load1");
    wr32(A_CTRL, 32'b101, "t6_ctrl");
    rd32(A_STATUS, "t6_st");
    wr32(A_LOAD, 32'd5, "t6_load5");
    wr32(A_CTRL, 32'b100, "t6_dis");
    wr32(A_CTRL, 32'b101, "t6_en");
    @(negedge clk);
    memaddr = A_COUNT; memwrite = 0; memread = 1; be = '0;
    #1;
    check("t6_count5", readdata, 32'd5);
    check("t6_nirq_pre", {31'd0, nIRQ}, 32'd0);
    #1 reset = 1'b1;
    #1;
    check("t6_count_rst", readdata, 32'd0);
    check("t6_nirq_rst", {31'd0, nIRQ}, 32'd1);
    memaddr = A_CTRL;
    #1;
    check("t6_ctrl_rst", readdata, 32'd0);
    model_reset();
    @(negedge clk);
    reset = 1'b0;
    rd32(32'h10, "t6_ram_kept");
    rd32(A_STATUS, "t6_status");

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
